add_tree_acc: RTL

- Sequential accumulator directly downstream of the 4-bit adder-tree stage.
- Consumes one IN_W-bit partial sum per accepted beat over a frame of programmable length.
- Emits the saturating frame total with an overflow flag over a valid/ready handshake.
- Turns the combinational tree into a multi-cycle reduction engine for downstream consumers.

---
 rtl/add_tree_acc_if.sv | 26 ++
 rtl/add_tree_acc.sv | 105 ++++++++++
 2 files changed

// File: rtl/add_tree_acc_if.sv
// Handshake bundle between the adder tree, the frame accumulator
// and the downstream consumer of frame totals.
interface add_tree_acc_if #(
    parameter int IN_W  = 4,
    parameter int ACC_W = 12,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [CNT_W-1:0] frame_len;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, frame_len, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_data, frame_len, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/add_tree_acc.sv
// Frame accumulator behind the adder tree: sums partial sums over a
// programmable number of beats and hands out a saturated total.
module add_tree_acc #(
    parameter int IN_W  = 4,
    parameter int ACC_W = 12,
    parameter int CNT_W = 8
) (
    input  logic          CLK,
    input  logic          RST,
    add_tree_acc_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             xfer;
    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] eff_len;
    logic [CNT_W-1:0] cnt_inc;

    assign accept = bus.in_valid & in_ready_q;
    assign xfer   = out_valid_q & bus.out_ready;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = acc_q;
    assign bus.out_ovf   = ovf_q;

    // Next-state, datapath and registered handshake outputs.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        sum     = (ACC_W+1)'(acc_q) + (ACC_W+1)'(bus.in_data);
        cnt_inc = cnt_q + CNT_W'(1);
        eff_len = (bus.frame_len == '0) ? CNT_W'(1) : bus.frame_len;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    len_d   = eff_len;
                    acc_d   = ACC_W'(bus.in_data);
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (eff_len == CNT_W'(1)) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    if (sum[ACC_W]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (xfer) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d != HOLD);
        out_valid_d = (state_d == HOLD);
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule
